mod6_counter: RTL and testbench
===============================

MOD6_COUNTER -- requirements
Module: mod6_counter

Interface
REQ-001 The block SHALL have parameter MODULUS, default 6, giving the count modulus (legal range 2..16).
REQ-002 The block SHALL have parameter WIDTH, default 4, giving the width of out (must satisfy 2^WIDTH >= MODULUS).
REQ-003 The block SHALL have a single clock and an asynchronous, active-low reset, named clk and rst as the codebase does.
REQ-004 Port: clk  input  1  rising-edge system clock (1 s tick in the clock design).
REQ-005 Port: rst  input  1  asynchronous active-low reset.
REQ-006 Port: key  input  1  count enable (active high); chains from the previous stage's carry or the set key.
REQ-007 Port: out  output  WIDTH  current count, binary, 0..MODULUS-1.
REQ-008 Port: en_out  output  1  carry/enable to the next stage, asserted for the terminal-count cycle.

Function
REQ-009 On each rising clk edge with rst high and key=1, out SHALL advance by 1 when out < MODULUS-1.
REQ-010 On a rising clk edge with key=1 and out = MODULUS-1, out SHALL wrap to 0.
REQ-011 On a rising clk edge with key=0, out SHALL hold its value.
REQ-012 If out >= MODULUS (illegal state), the next clk edge SHALL load 0 regardless of key.
REQ-013 Default en_out SHALL be combinational: en_out = key AND (out = MODULUS-1); high in exactly the cycle before the wrap.
REQ-014 en_out SHALL be 0 whenever key=0, including when out = MODULUS-1.
REQ-015 Latency: out changes one clk edge after the enabled edge; no pipelining beyond the single count register.
REQ-016 Count arithmetic SHALL be unsigned WIDTH-bit; no intermediate value wider than WIDTH is stored.
REQ-017 With key held high, en_out SHALL pulse once every MODULUS clocks (period 6 at default).

Reset
REQ-018 Assertion of rst (low) SHALL immediately, without waiting for clk, force out = 0.
REQ-019 While rst is low, out SHALL stay 0, en_out SHALL be 0, and clk/key SHALL be ignored.
REQ-020 After rst deasserts, the first enabled rising edge SHALL produce out = 1.
REQ-021 Reset asserted mid-count (any out value) SHALL behave identically to reset from power-up.

Configuration
REQ-022 Macro MOD6_COUNTER_REG_CARRY_EN, when defined, SHALL make en_out a registered output.
REQ-023 With MOD6_COUNTER_REG_CARRY_EN defined, en_out SHALL be set on the edge where out wraps MODULUS-1 -> 0, SHALL be high for exactly that one following cycle, and SHALL reset to 0 asynchronously.
REQ-024 Without MOD6_COUNTER_REG_CARRY_EN, en_out SHALL be the combinational term of REQ-013.

Verification
REQ-025 rst=0 with key=1 and clk running -> out=0, en_out=0 throughout; out becomes 1 on the first edge after rst=1.
REQ-026 rst=1, key=1, 5 edges -> out=5, en_out=1 (default build); 6th edge -> out=0, en_out=0.
REQ-027 key=1 for 12 edges from 0 -> out sequence 1,2,3,4,5,0,1,2,3,4,5,0; en_out high exactly twice.
REQ-028 out=5 then key=0 for 4 edges -> out holds 5, en_out=0; key=1 plus one edge -> out=0.
REQ-029 out=3, rst pulsed low between clock edges -> out=0 immediately, before the next clk edge.
REQ-030 MOD6_COUNTER_REG_CARRY_EN build, key=1 -> en_out high only during the cycle after out goes 5 -> 0.

Source files
------------

// File: rtl/mod6_counter.sv
// Modulo-MODULUS enable-chained counter stage with carry output for cascading.
// Define MOD6_COUNTER_REG_CARRY_EN to register en_out (one cycle after the wrap edge).
module mod6_counter #(
  parameter int MODULUS = 6,
  parameter int WIDTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key,
  output logic [WIDTH-1:0] out,
  output logic             en_out
);

  localparam logic [WIDTH-1:0] LP_TERM = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] LP_ONE  = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next;
  logic             w_at_term;
  logic             w_illegal;
  logic             w_wrap;

  assign w_at_term = (r_count == LP_TERM);
  assign w_illegal = (r_count > LP_TERM);
  assign w_wrap    = key & w_at_term;

  // Next-count selection; an out-of-range count recovers to zero regardless of key.
  always_comb begin
    w_next = r_count;
    if (w_illegal) begin
      w_next = '0;
    end else if (key) begin
      if (w_at_term) begin
        w_next = '0;
      end else begin
        w_next = r_count + LP_ONE;
      end
    end else begin
      w_next = r_count;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_next;
    end
  end

  assign out = r_count;

`ifdef MOD6_COUNTER_REG_CARRY_EN
  logic r_en_out;

  // Carry registered on the wrap edge, so it is high for the first cycle at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en_out <= 1'b0;
    end else begin
      r_en_out <= w_wrap & ~w_illegal;
    end
  end

  assign en_out = r_en_out;
`else
  assign en_out = w_wrap;
`endif

endmodule

// File: tb/tb_mod6_counter.sv
// Directed self-checking bench for mod6_counter (default MODULUS=6, WIDTH=4).
// Honours MOD6_COUNTER_REG_CARRY_EN when the bench and RTL are built with it.
module tb_mod6_counter;

  logic       clk;
  logic       rst;
  logic       key;
  logic [3:0] out;
  logic       en_out;

  int checks   = 0;
  int failures = 0;

  mod6_counter #(.MODULUS(6), .WIDTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .key    (key),
    .out    (out),
    .en_out (en_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse applied between edges.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    key = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out !== 4'd0) begin
        failures++;
        $display("FAIL reset_hold_out cycle %0d: got %0d expected 0", i, out);
      end
      checks++;
      if (en_out !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold_en cycle %0d: got %b expected 0", i, en_out);
      end
    end
    rst = 1'b1;
    tick();
    checks++;
    if (out !== 4'd1) begin
      failures++;
      $display("FAIL reset_first_edge: got %0d expected 1", out);
    end
  endtask

  task automatic test_count_to_terminal();
    logic exp_en;
    key = 1'b0;
    do_reset();
    key = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (out !== 4'(i)) begin
        failures++;
        $display("FAIL count_up step %0d: got %0d expected %0d", i, out, i);
      end
    end
`ifdef MOD6_COUNTER_REG_CARRY_EN
    exp_en = 1'b0;
`else
    exp_en = 1'b1;
`endif
    checks++;
    if (en_out !== exp_en) begin
      failures++;
      $display("FAIL terminal_en: got %b expected %b", en_out, exp_en);
    end
    tick();
    checks++;
    if (out !== 4'd0) begin
      failures++;
      $display("FAIL wrap_out: got %0d expected 0", out);
    end
`ifdef MOD6_COUNTER_REG_CARRY_EN
    exp_en = 1'b1;
`else
    exp_en = 1'b0;
`endif
    checks++;
    if (en_out !== exp_en) begin
      failures++;
      $display("FAIL wrap_en: got %b expected %b", en_out, exp_en);
    end
  endtask

  task automatic test_wrap_sequence();
    logic [3:0] exp_seq [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0,
                                  4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0};
    logic exp_en;
    int   en_high = 0;
    key = 1'b0;
    do_reset();
    key = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (out !== exp_seq[i]) begin
        failures++;
        $display("FAIL seq_out step %0d: got %0d expected %0d", i, out, exp_seq[i]);
      end
`ifdef MOD6_COUNTER_REG_CARRY_EN
      exp_en = (exp_seq[i] == 4'd0);
`else
      exp_en = (exp_seq[i] == 4'd5);
`endif
      checks++;
      if (en_out !== exp_en) begin
        failures++;
        $display("FAIL seq_en step %0d: got %b expected %b", i, en_out, exp_en);
      end
      if (en_out === 1'b1) en_high++;
    end
    checks++;
    if (en_high !== 2) begin
      failures++;
      $display("FAIL seq_en_count: got %0d expected 2", en_high);
    end
  endtask

  task automatic test_hold();
    logic exp_en;
    key = 1'b0;
    do_reset();
    key = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    key = 1'b0;
    #1;
    checks++;
    if (en_out !== 1'b0) begin
      failures++;
      $display("FAIL hold_en_keylow: got %b expected 0", en_out);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (out !== 4'd5) begin
        failures++;
        $display("FAIL hold_out cycle %0d: got %0d expected 5", i, out);
      end
      checks++;
      if (en_out !== 1'b0) begin
        failures++;
        $display("FAIL hold_en cycle %0d: got %b expected 0", i, en_out);
      end
    end
    key = 1'b1;
    tick();
    checks++;
    if (out !== 4'd0) begin
      failures++;
      $display("FAIL hold_release_out: got %0d expected 0", out);
    end
`ifdef MOD6_COUNTER_REG_CARRY_EN
    exp_en = 1'b1;
`else
    exp_en = 1'b0;
`endif
    checks++;
    if (en_out !== exp_en) begin
      failures++;
      $display("FAIL hold_release_en: got %b expected %b", en_out, exp_en);
    end
  endtask

  task automatic test_async_reset_midcount();
    key = 1'b0;
    do_reset();
    key = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (out !== 4'd3) begin
      failures++;
      $display("FAIL midcount_setup: got %0d expected 3", out);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (out !== 4'd0) begin
      failures++;
      $display("FAIL async_reset_out: got %0d expected 0", out);
    end
    checks++;
    if (en_out !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_en: got %b expected 0", en_out);
    end
    tick();
    checks++;
    if (out !== 4'd0) begin
      failures++;
      $display("FAIL async_reset_held: got %0d expected 0", out);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (out !== 4'd1) begin
      failures++;
      $display("FAIL async_reset_resume: got %0d expected 1", out);
    end
  endtask

  initial begin
    rst = 1'b0;
    key = 1'b0;
    test_reset();
    test_count_to_terminal();
    test_wrap_sequence();
    test_hold();
    test_async_reset_midcount();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
